// File: rtl/l2_cache_update_queue.sv
// L2 update stage: merges store data into the cache line, drives the data-array
// write-back, and queues one response per completed request toward the cores.
module l2_cache_update_queue #(
    parameter int LINE_BYTES      = 64,
    parameter int CACHE_IDX_W     = 10,
    parameter int CORE_W          = 2,
    parameter int ID_W            = 2,
    parameter int ADDR_W          = 26,
    parameter int RSP_DEPTH       = 4,
    parameter int STALL_SLACK     = 2,
    parameter bit OVERFLOW_ASSERT = 1'b1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        req_valid,
    input  logic [2:0]                  req_type,
    input  logic [CORE_W-1:0]           req_core,
    input  logic [ID_W-1:0]             req_id,
    input  logic                        req_cache_type,
    input  logic [ADDR_W-1:0]           req_addr,
    input  logic [LINE_BYTES-1:0]       req_store_mask,
    input  logic [LINE_BYTES*8-1:0]     req_data,
    input  logic                        cache_hit,
    input  logic [CACHE_IDX_W-1:0]      hit_idx,
    input  logic                        l2_fill,
    input  logic                        restarted_flush,
    input  logic                        needs_writeback,
    input  logic                        sync_success,
    input  logic [LINE_BYTES*8-1:0]     line_data,
    input  logic [LINE_BYTES*8-1:0]     mem_data,
    output logic                        wr_en,
    output logic [CACHE_IDX_W-1:0]      wr_idx,
    output logic [LINE_BYTES*8-1:0]     wr_data,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [CORE_W-1:0]           rsp_core,
    output logic [ID_W-1:0]             rsp_id,
    output logic [2:0]                  rsp_type,
    output logic                        rsp_cache_type,
    output logic                        rsp_status,
    output logic [ADDR_W-1:0]           rsp_addr,
    output logic [LINE_BYTES*8-1:0]     rsp_data,
    output logic [$clog2(RSP_DEPTH):0]  rsp_count,
    output logic                        stall_out,
    output logic                        overflow
);
    localparam int DATA_W = LINE_BYTES * 8;
    localparam int PTR_W  = $clog2(RSP_DEPTH);
    localparam int CNT_W  = $clog2(RSP_DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT    = CNT_W'(RSP_DEPTH);
    localparam logic [CNT_W-1:0] STALL_THRESH = CNT_W'(RSP_DEPTH - STALL_SLACK);

    localparam logic [2:0] REQ_LOAD       = 3'd0;
    localparam logic [2:0] REQ_STORE      = 3'd1;
    localparam logic [2:0] REQ_FLUSH      = 3'd2;
    localparam logic [2:0] REQ_IINV       = 3'd3;
    localparam logic [2:0] REQ_DINV       = 3'd4;
    localparam logic [2:0] REQ_LOAD_SYNC  = 3'd5;
    localparam logic [2:0] REQ_STORE_SYNC = 3'd6;

    localparam logic [2:0] RSP_LOAD_ACK  = 3'd0;
    localparam logic [2:0] RSP_STORE_ACK = 3'd1;
    localparam logic [2:0] RSP_FLUSH_ACK = 3'd2;
    localparam logic [2:0] RSP_IINV_ACK  = 3'd3;
    localparam logic [2:0] RSP_DINV_ACK  = 3'd4;

    typedef struct packed {
        logic [CORE_W-1:0] core;
        logic [ID_W-1:0]   id;
        logic [2:0]        rtype;
        logic              cache_type;
        logic              status;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } rsp_entry_t;

    logic              is_store, is_store_sync, is_flush, is_inv, upd;
    logic [DATA_W-1:0] base_line, merged;
    logic              enq, deq, full, accept;
    rsp_entry_t        new_entry, head;
    rsp_entry_t        fifo_mem [RSP_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              overflow_q;

    assign is_store      = (req_type == REQ_STORE);
    assign is_store_sync = (req_type == REQ_STORE_SYNC);
    assign is_flush      = (req_type == REQ_FLUSH);
    assign is_inv        = (req_type == REQ_IINV) || (req_type == REQ_DINV);
    assign upd           = is_store || (is_store_sync && sync_success);
    assign base_line     = l2_fill ? mem_data : line_data;

    always_comb begin
        merged = base_line;
        for (int b = 0; b < LINE_BYTES; b++) begin
            if (upd && req_store_mask[b]) merged[b*8 +: 8] = req_data[b*8 +: 8];
        end
    end

    assign wr_en   = !reset && req_valid &&
                     (l2_fill || (cache_hit && (is_store || is_store_sync)));
    assign wr_idx  = hit_idx;
    assign wr_data = merged;

    // A dirty flush hit writes back first and only acknowledges on its restarted pass.
    assign enq = !reset && req_valid &&
                 ((cache_hit && !is_flush) || l2_fill ||
                  (is_flush && (restarted_flush || !cache_hit || !needs_writeback)) ||
                  is_inv);

    always_comb begin
        new_entry            = '0;
        new_entry.core       = req_core;
        new_entry.id         = req_id;
        new_entry.cache_type = req_cache_type;
        new_entry.status     = is_store_sync ? sync_success : 1'b1;
        new_entry.addr       = req_addr;
        new_entry.data       = merged;
        case (req_type)
            REQ_LOAD, REQ_LOAD_SYNC:   new_entry.rtype = RSP_LOAD_ACK;
            REQ_STORE, REQ_STORE_SYNC: new_entry.rtype = RSP_STORE_ACK;
            REQ_FLUSH:                 new_entry.rtype = RSP_FLUSH_ACK;
            REQ_IINV:                  new_entry.rtype = RSP_IINV_ACK;
            REQ_DINV:                  new_entry.rtype = RSP_DINV_ACK;
            default:                   new_entry.rtype = RSP_LOAD_ACK;
        endcase
    end

    // valid/ready: the head entry leaves on a cycle where rsp_valid and rsp_ready are both high.
    assign rsp_valid = !reset && (count != '0);
    assign deq       = rsp_valid && rsp_ready;
    assign full      = (count == DEPTH_CNT);
    assign accept    = enq && (!full || deq);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + PTR_W'(1);
            if (deq)    rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(accept) - CNT_W'(deq);
            if (enq && full && !deq) overflow_q <= 1'b1;
        end
    end

    // Storage is left uncleared; the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (accept) fifo_mem[wr_ptr] <= new_entry;
    end

    assign head           = fifo_mem[rd_ptr];
    assign rsp_core       = head.core;
    assign rsp_id         = head.id;
    assign rsp_type       = head.rtype;
    assign rsp_cache_type = head.cache_type;
    assign rsp_status     = head.status;
    assign rsp_addr       = head.addr;
    assign rsp_data       = head.data;
    assign rsp_count      = count;
    assign stall_out      = !reset && (count >= STALL_THRESH);
    assign overflow       = overflow_q;

    always_ff @(posedge clk) begin
        if (!reset && req_valid) begin
            a_rflush_is_flush: assert (!restarted_flush || is_flush);
            a_rflush_not_fill: assert (!(restarted_flush && l2_fill));
        end
        // Environments that deliberately exercise the sticky drop flag can turn this off.
        if (OVERFLOW_ASSERT && !reset) begin
            a_no_drop: assert (!(enq && full && !deq));
        end
    end
endmodule

// File: tb/tb_l2_cache_update_queue.sv
// Self-checking bench for l2_cache_update_queue: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_l2_cache_update_queue;
    localparam int LB = 64, DW = 512, IW = 10, CW = 2, QW = 2, AW = 26;
    localparam int DEPTH = 4, SLACK = 2;
    localparam int RW = CW + QW + 3 + 1 + 1 + AW + DW;

    logic clk = 1'b0;
    logic reset;
    logic req_valid, req_cache_type, cache_hit, l2_fill, restarted_flush;
    logic needs_writeback, sync_success, rsp_ready;
    logic [2:0] req_type;
    logic [CW-1:0] req_core;
    logic [QW-1:0] req_id;
    logic [AW-1:0] req_addr;
    logic [LB-1:0] req_store_mask;
    logic [DW-1:0] req_data, line_data, mem_data;
    logic [IW-1:0] hit_idx;
    logic wr_en, rsp_valid, rsp_cache_type, rsp_status, stall_out, overflow;
    logic [IW-1:0] wr_idx;
    logic [DW-1:0] wr_data, rsp_data;
    logic [CW-1:0] rsp_core;
    logic [QW-1:0] rsp_id;
    logic [2:0] rsp_type;
    logic [AW-1:0] rsp_addr;
    logic [2:0] rsp_count;

    int vectors = 0;
    int miscompares = 0;
    logic [RW-1:0] exp_q[$];
    logic m_ovf;

    always #5 clk = ~clk;

    l2_cache_update_queue #(
        .LINE_BYTES(LB), .CACHE_IDX_W(IW), .CORE_W(CW), .ID_W(QW), .ADDR_W(AW),
        .RSP_DEPTH(DEPTH), .STALL_SLACK(SLACK), .OVERFLOW_ASSERT(1'b0)
    ) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_type(req_type),
        .req_core(req_core), .req_id(req_id), .req_cache_type(req_cache_type),
        .req_addr(req_addr), .req_store_mask(req_store_mask), .req_data(req_data),
        .cache_hit(cache_hit), .hit_idx(hit_idx), .l2_fill(l2_fill),
        .restarted_flush(restarted_flush), .needs_writeback(needs_writeback),
        .sync_success(sync_success), .line_data(line_data), .mem_data(mem_data),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_core(rsp_core), .rsp_id(rsp_id),
        .rsp_type(rsp_type), .rsp_cache_type(rsp_cache_type), .rsp_status(rsp_status),
        .rsp_addr(rsp_addr), .rsp_data(rsp_data), .rsp_count(rsp_count),
        .stall_out(stall_out), .overflow(overflow)
    );

    function automatic logic [DW-1:0] rand_line();
        logic [DW-1:0] v;
        for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Reference model: line merge, write decision, response decision and entry.
    function automatic logic [DW-1:0] m_wr_data();
        logic [DW-1:0] line;
        logic store_like;
        line = l2_fill ? mem_data : line_data;
        store_like = (req_type == 3'd1) || (req_type == 3'd6 && sync_success);
        for (int b = 0; b < LB; b++)
            if (store_like && req_store_mask[b]) line[b*8 +: 8] = req_data[b*8 +: 8];
        return line;
    endfunction

    function automatic logic m_wr_en();
        return !reset && req_valid &&
               (l2_fill || (cache_hit && (req_type == 3'd1 || req_type == 3'd6)));
    endfunction

    function automatic logic m_enq();
        logic fl;
        fl = (req_type == 3'd2);
        return !reset && req_valid &&
               ((cache_hit && !fl) || l2_fill ||
                (fl && (restarted_flush || !cache_hit || !needs_writeback)) ||
                req_type == 3'd3 || req_type == 3'd4);
    endfunction

    function automatic logic [RW-1:0] m_entry();
        logic [2:0] t;
        logic st;
        case (req_type)
            3'd1, 3'd6: t = 3'd1;
            3'd2:       t = 3'd2;
            3'd3:       t = 3'd3;
            3'd4:       t = 3'd4;
            default:    t = 3'd0;
        endcase
        st = (req_type == 3'd6) ? sync_success : 1'b1;
        return {req_core, req_id, t, req_cache_type, st, req_addr, m_wr_data()};
    endfunction

    function automatic logic [RW-1:0] dut_head();
        return {rsp_core, rsp_id, rsp_type, rsp_cache_type, rsp_status, rsp_addr, rsp_data};
    endfunction

    task automatic set_idle();
        req_valid = 1'b0; req_type = 3'd0; cache_hit = 1'b0; l2_fill = 1'b0;
        restarted_flush = 1'b0; needs_writeback = 1'b0; sync_success = 1'b0;
        req_core = '0; req_id = '0; req_cache_type = 1'b0; req_addr = '0;
        req_store_mask = '0; req_data = '0; line_data = '0; mem_data = '0; hit_idx = '0;
    endtask

    task automatic set_req(input logic [2:0] t, input logic hit, input logic fill,
                           input logic rfl, input logic nwb, input logic sync);
        req_valid = 1'b1; req_type = t; cache_hit = hit; l2_fill = fill;
        restarted_flush = rfl; needs_writeback = nwb; sync_success = sync;
        req_core = CW'($urandom); req_id = QW'($urandom);
        req_cache_type = 1'($urandom); req_addr = AW'($urandom); hit_idx = IW'($urandom);
        req_store_mask = {$urandom, $urandom};
        req_data = rand_line(); line_data = rand_line(); mem_data = rand_line();
    endtask

    // Advances one clock and applies the model's enqueue/dequeue for that edge.
    task automatic tick();
        logic e, d, was_full;
        logic [RW-1:0] ent;
        e = m_enq();
        d = (exp_q.size() != 0) && rsp_ready;
        was_full = (exp_q.size() == DEPTH);
        ent = m_entry();
        @(posedge clk);
        #1;
        if (reset) begin
            exp_q.delete();
            m_ovf = 1'b0;
        end else begin
            if (d) void'(exp_q.pop_front());
            if (e && was_full && !d) m_ovf = 1'b1;
            else if (e) exp_q.push_back(ent);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; rsp_ready = 1'b1;
        set_req(3'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        #1;
        vectors++; if (wr_en !== 1'b0) begin miscompares++; $display("FAIL reset_wr_en: got %b want 0", wr_en); end
        vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        vectors++; if (stall_out !== 1'b0) begin miscompares++; $display("FAIL reset_stall: got %b want 0", stall_out); end
        set_idle();
        tick();
        reset = 1'b0;
        #1;
        vectors++; if (rsp_count !== 3'd0) begin miscompares++; $display("FAIL reset_count: got %0d want 0", rsp_count); end
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL post_reset_valid: got %b want 0", rsp_valid); end
    endtask

    task automatic test_load_hit();
        rsp_ready = 1'b1;
        set_req(3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        line_data = {LB{8'hAA}};
        #1;
        vectors++; if (wr_en !== 1'b0) begin miscompares++; $display("FAIL load_wr_en: got %b want 0", wr_en); end
        tick(); set_idle(); #1;
        vectors++; if (rsp_valid !== 1'b1) begin miscompares++; $display("FAIL load_valid: got %b want 1", rsp_valid); end
        vectors++; if (rsp_type !== 3'd0 || rsp_status !== 1'b1) begin miscompares++; $display("FAIL load_type_status: got %0d/%b want 0/1", rsp_type, rsp_status); end
        vectors++; if (rsp_data !== {LB{8'hAA}}) begin miscompares++; $display("FAIL load_data: got %h want all AA", rsp_data); end
        tick(); #1;
        vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL load_drain: got %b want 0", rsp_valid); end
    endtask

    task automatic test_store();
        logic [DW-1:0] e;
        logic [DW-1:0] line;
        rsp_ready = 1'b1;
        set_req(3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        req_store_mask = 64'hF; req_data = {LB{8'h11}}; line_data = '0;
        e = '0; e[31:0] = 32'h11111111;
        #1;
        vectors++; if (wr_en !== 1'b1) begin miscompares++; $display("FAIL store_wr_en: got %b want 1", wr_en); end
        vectors++; if (wr_data !== e) begin miscompares++; $display("FAIL store_merge: got %h want %h", wr_data, e); end
        tick(); set_idle(); #1;
        vectors++; if (rsp_type !== 3'd1 || rsp_status !== 1'b1 || rsp_data !== e) begin miscompares++; $display("FAIL store_rsp: got type %0d status %b", rsp_type, rsp_status); end
        tick();
        set_req(3'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        req_store_mask = '1; line = line_data;
        #1;
        vectors++; if (wr_en !== 1'b1) begin miscompares++; $display("FAIL ssync_wr_en: got %b want 1", wr_en); end
        vectors++; if (wr_data !== line) begin miscompares++; $display("FAIL ssync_data: got %h want %h", wr_data, line); end
        tick(); set_idle(); #1;
        vectors++; if (rsp_valid !== 1'b1 || rsp_type !== 3'd1 || rsp_status !== 1'b0) begin miscompares++; $display("FAIL ssync_rsp: got valid %b type %0d status %b want 1/1/0", rsp_valid, rsp_type, rsp_status); end
        tick();
    endtask

    task automatic test_fill();
        logic [DW-1:0] e;
        rsp_ready = 1'b1;
        set_req(3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        mem_data = {LB{8'h55}}; req_store_mask = 64'h1; req_data[7:0] = 8'h77;
        e = {LB{8'h55}}; e[7:0] = 8'h77;
        #1;
        vectors++; if (wr_en !== 1'b1 || wr_data !== e) begin miscompares++; $display("FAIL fill_merge: got en %b data %h want 1 %h", wr_en, wr_data, e); end
        tick(); set_idle(); #1;
        vectors++; if (rsp_valid !== 1'b1 || rsp_data !== e) begin miscompares++; $display("FAIL fill_rsp: got valid %b data %h", rsp_valid, rsp_data); end
        tick();
    endtask

    task automatic test_flush();
        logic [CW-1:0] c;
        logic [QW-1:0] i;
        logic [AW-1:0] a;
        rsp_ready = 1'b1;
        set_req(3'd2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        c = req_core; i = req_id; a = req_addr;
        tick(); set_idle(); #1;
        vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL flush_dirty_norsp: got %b want 0", rsp_valid); end
        set_req(3'd2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        req_core = c; req_id = i; req_addr = a;
        tick(); set_idle(); #1;
        vectors++; if (rsp_valid !== 1'b1 || rsp_type !== 3'd2 || rsp_addr !== a) begin miscompares++; $display("FAIL flush_restart: got valid %b type %0d addr %h want 1/2/%h", rsp_valid, rsp_type, rsp_addr, a); end
        tick(); #1;
        vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL flush_single: got %b want 0", rsp_valid); end
        set_req(3'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick(); set_idle(); #1;
        vectors++; if (rsp_valid !== 1'b1 || rsp_type !== 3'd2) begin miscompares++; $display("FAIL flush_miss: got valid %b type %0d want 1/2", rsp_valid, rsp_type); end
        tick();
    endtask

    task automatic drain_check(input string name, input int n);
        rsp_ready = 1'b1;
        for (int k = 0; k < n; k++) begin
            #1;
            vectors++;
            if (rsp_valid !== 1'b1 || exp_q.size() == 0 || dut_head() !== exp_q[0]) begin
                miscompares++;
                $display("FAIL %s_order%0d: got valid %b head %h", name, k, rsp_valid, dut_head());
            end
            tick();
        end
        #1;
        vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL %s_empty: got %b want 0", name, rsp_valid); end
    endtask

    task automatic test_backpressure();
        rsp_ready = 1'b0;
        for (int n = 1; n <= 5; n++) begin
            set_req(3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            tick(); set_idle(); #1;
            vectors++;
            if (rsp_count !== 3'((n > 4) ? 4 : n) || stall_out !== (n >= 2) || overflow !== (n >= 5)) begin
                miscompares++;
                $display("FAIL bp_enq%0d: got count %0d stall %b ovf %b", n, rsp_count, stall_out, overflow);
            end
        end
        drain_check("bp", 4);
    endtask

    task automatic test_reset_mid();
        rsp_ready = 1'b0;
        for (int n = 0; n < 3; n++) begin
            set_req(3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            tick();
        end
        set_idle(); #1;
        vectors++; if (rsp_count !== 3'd3) begin miscompares++; $display("FAIL mid_count: got %0d want 3", rsp_count); end
        reset = 1'b1;
        tick();
        reset = 1'b0; #1;
        vectors++; if (rsp_valid !== 1'b0 || rsp_count !== 3'd0 || overflow !== 1'b0) begin miscompares++; $display("FAIL mid_reset: got valid %b count %0d ovf %b want 0/0/0", rsp_valid, rsp_count, overflow); end
    endtask

    task automatic test_full_enq_deq();
        rsp_ready = 1'b0;
        for (int n = 0; n < 4; n++) begin
            set_req(3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            tick();
        end
        set_req(3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        rsp_ready = 1'b1;
        tick(); set_idle(); rsp_ready = 1'b0; #1;
        vectors++; if (rsp_count !== 3'd4 || overflow !== 1'b0) begin miscompares++; $display("FAIL full_both: got count %0d ovf %b want 4/0", rsp_count, overflow); end
        drain_check("full", 4);
    endtask

    task automatic test_random();
        logic [2:0] t;
        logic fill;
        for (int n = 0; n < 400; n++) begin
            t = 3'($urandom_range(0, 7));
            fill = ($urandom_range(0, 3) == 0);
            set_req(t, 1'($urandom), fill, (t == 3'd2) && !fill && 1'($urandom),
                    1'($urandom), 1'($urandom));
            req_valid = (exp_q.size() < DEPTH - SLACK) && ($urandom_range(0, 3) != 0);
            rsp_ready = ($urandom_range(0, 2) != 0);
            reset = ($urandom_range(0, 60) == 0);
            #1;
            vectors++;
            if (wr_en !== m_wr_en() || wr_data !== m_wr_data() || wr_idx !== hit_idx) begin
                miscompares++;
                $display("FAIL rnd_write%0d: got en %b idx %h want en %b", n, wr_en, wr_idx, m_wr_en());
            end
            vectors++;
            if (rsp_valid !== (!reset && exp_q.size() != 0) || rsp_count !== 3'(exp_q.size()) ||
                stall_out !== (!reset && exp_q.size() >= DEPTH - SLACK) || overflow !== m_ovf) begin
                miscompares++;
                $display("FAIL rnd_state%0d: got valid %b count %0d stall %b ovf %b want count %0d",
                         n, rsp_valid, rsp_count, stall_out, overflow, exp_q.size());
            end
            if (!reset && exp_q.size() != 0) begin
                vectors++;
                if (dut_head() !== exp_q[0]) begin
                    miscompares++;
                    $display("FAIL rnd_head%0d: got %h want %h", n, dut_head(), exp_q[0]);
                end
            end
            tick();
        end
        reset = 1'b0;
    endtask

    initial begin
        m_ovf = 1'b0;
        reset = 1'b1;
        rsp_ready = 1'b0;
        set_idle();
        test_reset();
        test_load_hit();
        test_store();
        test_fill();
        test_flush();
        test_backpressure();
        test_reset_mid();
        test_full_enq_deq();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
